input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Front-end for the 4x4 grid game. Sits between board pins (btnU, sw[3:0], sw[5]) and grid-cell array.
//  Synchronises and debounces the fire button, nRow switch and four row/column switches.
//  Validates the switch field as one-hot and drives registered row/col enables plus a single-cycle fire pulse.
//  Grid cells consume row_sel/col_sel/fire_pulse directly; no debouncing happens downstream.
// PARAMETERS
//  DB_CYCLES    1_000_000  consecutive stable cycles to accept a new level (10 ms @ 100 MHz); >=2
//  SYNC_STAGES  2          synchroniser flops per raw input; >=2
//  CNT_W        $clog2(DB_CYCLES+1)  debounce counter width (derived, not overridden)
// PORTS
//  clk           in   1  system clock, 100 MHz
//  reset_n       in   1  asynchronous, active-low reset
//  fire_raw      in   1  fire pushbutton, bouncy, active-high
//  nrow_raw      in   1  row/column mode switch, bouncy; 0 = row mode, 1 = column mode
//  sw_raw        in   4  row/column select switches, bouncy
//  row_sel       out  4  one-hot row enable to grid; 0 in column mode
//  col_sel       out  4  one-hot column enable to grid; 0 in row mode
//  sel_valid     out  1  exactly one debounced switch is up
//  error         out  1  two or more debounced switches are up
//  fire_pulse    out  1  one-cycle strobe: accepted fire
//  fire_reject   out  1  one-cycle strobe: fire pressed while sel_valid=0
// BEHAVIOUR
//  Reset (reset_n=0, async): all sync flops, debounce counters, stable levels and outputs -> 0.
//   Reset mid-debounce discards the partial count. Post-reset stable levels are 0 regardless of pin state.
//   A pin already high at release debounces normally (DB_CYCLES) before its level is taken.
//  Sync: each raw bit passes SYNC_STAGES flops. No logic sits between synchroniser stages.
//  Debounce, per bit (6 instances):
//   - If sync == stable, count <= 0.
//   - Otherwise count increments.
//   - When count reaches DB_CYCLES-1 with sync still != stable: stable <= sync and count <= 0.
//   - Any single-cycle return to the old level clears the count.
//   - Latency from a clean raw edge to the stable edge is exactly SYNC_STAGES+DB_CYCLES clk cycles.
//  Selection stage, registered one cycle after the stable levels:
//   - one-hot sw_db: sel_valid=1, error=0. Row mode (nrow_db=0): row_sel<=sw_db, col_sel<=0. Column mode: swapped.
//   - sw_db==0: sel_valid=0, error=0, row_sel=col_sel=0.
//   - popcount(sw_db)>=2: error=1, sel_valid=0, row_sel/col_sel HOLD their previous values.
//   - An nRow toggle with a valid selection moves the enable between row_sel and col_sel in that same update.
//  Fire:
//   - rise = fire_db & ~fire_db_q.
//   - rise && sel_valid (current registered value): fire_pulse=1 for exactly one cycle.
//   - rise && !sel_valid: fire_reject=1 for exactly one cycle.
//   - fire_pulse and fire_reject are never high together.
//   - Button held: no further strobes. The next strobe needs release (debounced) and a new press.
//   - Rise in the same cycle as a selection update is gated by the pre-update sel_valid.
//   - fire_pulse is registered: one cycle after the rise.
//  Invariant: row_sel|col_sel is 0 or one-hot at all times, and never has bits set in both vectors.
// STRUCTURE
//  Shared header game_defs.vh: GRID_N=4; DB_CYCLES_HW=1_000_000; DB_CYCLES_SIM=4;
//   localparams MODE_ROW=1'b0, MODE_COL=1'b1.
//  Sub-module debounce_cell (params DB_CYCLES, SYNC_STAGES; ports clk, reset_n, d_raw, q_stable).
//   Instantiated 6x. Top level holds the selection regs, popcount/one-hot check and fire edge detect.
//  No FSM beyond the per-cell counter. Every flop is on clk with async reset_n.
// TESTING  (DB_CYCLES=4, SYNC_STAGES=2)
//  1. reset_n low with sw_raw=4'b0010, fire_raw=1 -> all outputs 0.
//     Release reset -> row_sel=0010 seven cycles after release (2+4+1), fire_reject strobe, no fire_pulse.
//  2. sw_raw 0000->0100 with bounces 1,0,1 every 2 cycles, then steady, nrow=0
//     -> row_sel=0100 exactly 7 cycles after the last bounce; no glitch on row_sel before that.
//  3. sw_raw=0001, nrow_raw 0->1 (clean) -> col_sel=0001 and row_sel=0000 in the same cycle, 7 cycles later.
//  4. sel 0001 valid, then sw_raw=0011 -> error=1, sel_valid=0, row_sel holds 0001.
//     Fire press -> one fire_reject, no fire_pulse.
//  5. sel valid, fire held high 50 cycles -> exactly one fire_pulse, 7 cycles after the press.
//     Release and re-press -> second pulse.
//  6. Assert reset_n low at count=2 of a fire debounce -> fire_pulse never fires for that press.
//     Counter restarts from 0 after release.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// ============================================================================
// Module      : input_conditioner_pkg
// Description : Shared constants, the selection classification type and its
//               helper function for the 4x4 grid game input front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_conditioner_pkg;

  // Grid dimension: four row/column select switches.
  localparam int GRID_N        = 4;

  // Debounce lengths: 10 ms at 100 MHz on hardware, short for simulation.
  localparam int DB_CYCLES_HW  = 1_000_000;
  localparam int DB_CYCLES_SIM = 4;

  // nRow switch encoding.
  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  // Classification of the debounced switch field.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,  // no switch up
    SEL_ONE   = 2'd1,  // exactly one switch up
    SEL_MULTI = 2'd2   // two or more switches up
  } sel_kind_e;

  function automatic sel_kind_e sel_class(input logic [GRID_N-1:0] sw);
    int ones;
    ones = 0;
    for (int i = 0; i < GRID_N; i++) begin
      ones += int'(sw[i]);
    end
    if (ones == 0) begin
      return SEL_NONE;
    end else if (ones == 1) begin
      return SEL_ONE;
    end
    return SEL_MULTI;
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
// ============================================================================
// Module      : debounce_cell
// Description : Synchroniser chain followed by a stable-level debouncer for
//               one raw board input.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in  1  system clock
//   reset_n   in  1  asynchronous active-low reset
//   d_raw     in  1  raw, bouncy, asynchronous input
//   q_stable  out 1  debounced level (0 after reset)
// ============================================================================
`default_nettype none

module debounce_cell #(
  parameter  int DB_CYCLES   = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int CNT_W       = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_raw,
  output logic q_stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   stable_q, stable_d;
  logic                   w_sync;

  // Plain shift chain: nothing combinational between synchroniser stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

  // The count only advances while the synchronised level differs from the
  // accepted one; any cycle back at the old level restarts it from zero.
  always_comb begin
    count_d  = '0;
    stable_d = stable_q;
    if (w_sync != stable_q) begin
      if (count_q == CNT_W'(DB_CYCLES - 1)) begin
        stable_d = w_sync;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      stable_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      stable_q <= stable_d;
    end
  end

  assign q_stable = stable_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module      : input_conditioner
// Description : Board-pin front-end for the 4x4 grid game. Debounces the fire
//               button, nRow switch and select switches, validates the
//               selection as one-hot and produces registered row/column
//               enables plus single-cycle fire / reject strobes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in  1  system clock (100 MHz)
//   reset_n      in  1  asynchronous active-low reset
//   fire_raw     in  1  fire pushbutton, active-high, bouncy
//   nrow_raw     in  1  mode switch: 0 = row mode, 1 = column mode
//   sw_raw       in  4  row/column select switches
//   row_sel      out 4  one-hot row enable (0 in column mode)
//   col_sel      out 4  one-hot column enable (0 in row mode)
//   sel_valid    out 1  exactly one debounced switch up
//   error        out 1  two or more debounced switches up
//   fire_pulse   out 1  one-cycle strobe: accepted fire
//   fire_reject  out 1  one-cycle strobe: fire without a valid selection
// ============================================================================
`default_nettype none

module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_HW,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fire_raw,
  input  logic              nrow_raw,
  input  logic [GRID_N-1:0] sw_raw,
  output logic [GRID_N-1:0] row_sel,
  output logic [GRID_N-1:0] col_sel,
  output logic              sel_valid,
  output logic              error,
  output logic              fire_pulse,
  output logic              fire_reject
);

  localparam int N_IN = GRID_N + 2;

  logic [N_IN-1:0]   w_raw;
  logic [N_IN-1:0]   w_db;
  logic [GRID_N-1:0] w_sw_db;
  logic              w_nrow_db;
  logic              w_fire_db;
  logic              w_rise;
  sel_kind_e         w_kind;

  logic [GRID_N-1:0] row_sel_q, row_sel_d;
  logic [GRID_N-1:0] col_sel_q, col_sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              error_q, error_d;
  logic              fire_db_q;
  logic              fire_pulse_q, fire_pulse_d;
  logic              fire_reject_q, fire_reject_d;

  // Bit layout: [GRID_N+1] fire, [GRID_N] nRow, [GRID_N-1:0] switches.
  assign w_raw = {fire_raw, nrow_raw, sw_raw};

  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_db
      debounce_cell #(
        .DB_CYCLES  (DB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .d_raw   (w_raw[i]),
        .q_stable(w_db[i])
      );
    end
  endgenerate

  assign w_sw_db   = w_db[GRID_N-1:0];
  assign w_nrow_db = w_db[GRID_N];
  assign w_fire_db = w_db[GRID_N+1];
  assign w_kind    = sel_class(w_sw_db);

  // Selection update. On a multi-switch error the enables keep their last
  // legal value, so row_sel|col_sel can never become non-one-hot.
  always_comb begin
    row_sel_d   = row_sel_q;
    col_sel_d   = col_sel_q;
    sel_valid_d = 1'b0;
    error_d     = 1'b0;
    case (w_kind)
      SEL_ONE: begin
        sel_valid_d = 1'b1;
        row_sel_d   = (w_nrow_db == MODE_ROW) ? w_sw_db : '0;
        col_sel_d   = (w_nrow_db == MODE_COL) ? w_sw_db : '0;
      end
      SEL_MULTI: begin
        error_d = 1'b1;
      end
      default: begin
        row_sel_d = '0;
        col_sel_d = '0;
      end
    endcase
  end

  // Gating uses the registered sel_valid, i.e. the value before any
  // selection update happening on the same edge.
  assign w_rise        = w_fire_db & ~fire_db_q;
  assign fire_pulse_d  = w_rise &  sel_valid_q;
  assign fire_reject_d = w_rise & ~sel_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_sel_q     <= '0;
      col_sel_q     <= '0;
      sel_valid_q   <= 1'b0;
      error_q       <= 1'b0;
      fire_db_q     <= 1'b0;
      fire_pulse_q  <= 1'b0;
      fire_reject_q <= 1'b0;
    end else begin
      row_sel_q     <= row_sel_d;
      col_sel_q     <= col_sel_d;
      sel_valid_q   <= sel_valid_d;
      error_q       <= error_d;
      fire_db_q     <= w_fire_db;
      fire_pulse_q  <= fire_pulse_d;
      fire_reject_q <= fire_reject_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_sel     = col_sel_q;
  assign sel_valid   = sel_valid_q;
  assign error       = error_q;
  assign fire_pulse  = fire_pulse_q;
  assign fire_reject = fire_reject_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner (DB_CYCLES=4,
//               SYNC_STAGES=2). Expected output words are queued with the
//               cycle they are due and compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;
  import input_conditioner_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             fire_raw;
  logic             nrow_raw;
  logic [3:0]       sw_raw;
  logic [3:0]       row_sel;
  logic [3:0]       col_sel;
  logic             sel_valid;
  logic             error;
  logic             fire_pulse;
  logic             fire_reject;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  input_conditioner #(
    .DB_CYCLES  (DB_CYCLES_SIM),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fire_raw   (fire_raw),
    .nrow_raw   (nrow_raw),
    .sw_raw     (sw_raw),
    .row_sel    (row_sel),
    .col_sel    (col_sel),
    .sel_valid  (sel_valid),
    .error      (error),
    .fire_pulse (fire_pulse),
    .fire_reject(fire_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    string       name;
    logic [11:0] exp;
  } sb_t;

  sb_t sbq[$];
  sb_t e;

  typedef struct {
    logic [3:0] sw;
    logic       nrow;
    logic [3:0] row;
    logic [3:0] col;
    logic       sv;
    logic       err;
  } vec_t;

  function automatic logic [11:0] pk(input logic [3:0] r, input logic [3:0] c,
                                     input logic sv, input logic er,
                                     input logic fp, input logic fr);
    return {r, c, sv, er, fp, fr};
  endfunction

  function automatic logic onehot0(input logic [3:0] v);
    logic [3:0] m;
    m = v - 4'd1;
    return (v & m) == 4'd0;
  endfunction

  // Insert keeping the queue ordered by due cycle.
  task automatic expect_at(input int off, input string nm, input logic [11:0] v);
    sb_t n;
    int  pos;
    n.due  = cyc + off;
    n.name = nm;
    n.exp  = v;
    pos = sbq.size();
    while (pos > 0 && sbq[pos-1].due > n.due) pos--;
    sbq.insert(pos, n);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries still pending, required 0", sbq.size());
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (!onehot0(row_sel | col_sel) || (row_sel & col_sel) != 4'd0
          || (fire_pulse & fire_reject)) begin
        errors++;
        $display("FAIL invariant @cyc %0d: row=%b col=%b fp=%b fr=%b, required one-hot/zero enables and exclusive strobes",
                 cyc, row_sel, col_sel, fire_pulse, fire_reject);
      end
    end
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: slot cyc %0d missed (now %0d)", e.name, e.due, cyc);
      end else if ({row_sel, col_sel, sel_valid, error, fire_pulse, fire_reject} !== e.exp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %b required %b (row,col,valid,error,pulse,reject)",
                 e.name, cyc, {row_sel, col_sel, sel_valid, error, fire_pulse, fire_reject}, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t tbl[9];
    tbl[0] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[1] = '{4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[2] = '{4'b1000, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[3] = '{4'b1100, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1};
    tbl[4] = '{4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[6] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0};
    tbl[7] = '{4'b0101, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
    tbl[8] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0};

    // 1. Reset with a valid switch and fire already high.
    reset_n  = 1'b0;
    sw_raw   = 4'b0010;
    fire_raw = 1'b1;
    nrow_raw = 1'b0;
    tick(2);
    expect_at(1, "t1_in_reset", 12'd0);
    tick(3);
    reset_n = 1'b1;
    expect_at(6, "t1_before", 12'd0);
    expect_at(7, "t1_reject", pk(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1));
    expect_at(8, "t1_after",  pk(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b0;
    expect_at(10, "t1_release", pk(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(12);

    // 2. Bouncy switch edge.
    sw_raw = 4'b0000;
    expect_at(7, "t2_clear", 12'd0);
    tick(10);
    sw_raw = 4'b0100;
    for (int k = 1; k <= 10; k++) expect_at(k, "t2_noglitch", 12'd0);
    expect_at(11, "t2_row", pk(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(2);
    sw_raw = 4'b0000;
    tick(2);
    sw_raw = 4'b0100;
    tick(12);

    // 3. Mode toggle moves the enable in one update.
    sw_raw = 4'b0001;
    expect_at(7, "t3_row", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    nrow_raw = 1'b1;
    expect_at(6, "t3_pre",  pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(7, "t3_swap", pk(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);

    // 4. Two switches up: error, hold, fire rejected.
    nrow_raw = 1'b0;
    expect_at(7, "t4_row", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    sw_raw = 4'b0011;
    expect_at(6, "t4_pre",   pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(7, "t4_error", pk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b1;
    expect_at(6, "t4_fire_pre",    pk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    expect_at(7, "t4_fire_reject", pk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    expect_at(8, "t4_fire_post",   pk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b0;
    tick(10);

    // 5. Held button: one pulse; release and re-press: second pulse.
    sw_raw = 4'b0001;
    expect_at(7, "t5_valid", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b1;
    for (int k = 1; k <= 50; k++)
      expect_at(k, "t5_hold", pk(4'b0001, 4'b0000, 1'b1, 1'b0, (k == 7), 1'b0));
    tick(50);
    fire_raw = 1'b0;
    expect_at(10, "t5_released", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b1;
    expect_at(6, "t5_repress_pre", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(7, "t5_repress",     pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));
    expect_at(8, "t5_repress_end", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(10);
    fire_raw = 1'b0;
    tick(10);

    // 6. Reset in the middle of a fire debounce.
    fire_raw = 1'b1;
    tick(4);
    reset_n  = 1'b0;
    fire_raw = 1'b0;
    expect_at(1, "t6_reset", 12'd0);
    expect_at(2, "t6_reset", 12'd0);
    tick(3);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) expect_at(k, "t6_post_reset", 12'd0);
    for (int k = 7; k <= 14; k++)
      expect_at(k, "t6_no_pulse", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(15);
    fire_raw = 1'b1;
    expect_at(6, "t6_press_pre", pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
    expect_at(7, "t6_press",     pk(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));
    tick(10);
    fire_raw = 1'b0;
    tick(10);

    // Table of steady-state selections.
    for (int i = 0; i < 9; i++) begin
      sw_raw   = tbl[i].sw;
      nrow_raw = tbl[i].nrow;
      expect_at(7, $sformatf("tbl%0d", i),
                pk(tbl[i].row, tbl[i].col, tbl[i].sv, tbl[i].err, 1'b0, 1'b0));
      expect_at(9, $sformatf("tbl%0d_hold", i),
                pk(tbl[i].row, tbl[i].col, tbl[i].sv, tbl[i].err, 1'b0, 1'b0));
      tick(10);
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
